// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end. Generates a predicted next PC from a
//            direct-mapped BTB with 2-bit direction counters, issues one
//            outstanding request at a time to the L1 instruction cache and
//            buffers returned instructions in a small circular fetch queue
//            that Decode drains. Execute-stage redirects flush the queue and
//            squash any in-flight cache response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TEXT_BASE    reset PC
//   BTB_ENTRIES  number of BTB entries (power of two, >= 2)
//   FQ_DEPTH     number of fetch-queue entries (power of two, >= 2)
// Ports
//   clk, rst          clock, synchronous active-high reset
//   imem_req/addr     cache request valid and fetch address
//   imem_rvalid/rdata cache response pulse and instruction word
//   inst_valid        queue head valid
//   inst/inst_pc      head instruction and its PC
//   pred_taken        head was predicted taken
//   pred_target       head predicted next PC
//   deq_ready         Decode consumes the head when inst_valid is high
//   redirect_valid/pc execute-stage redirect and corrected PC
//   upd_valid/pc/     resolved-branch BTB update: branch PC,
//   upd_taken/target  resolved direction and target
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned FQ_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction cache
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode side
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        deq_ready,
  // execute side
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;
  localparam int unsigned PTRW = $clog2(FQ_DEPTH);
  localparam logic [PTRW:0] FQ_FULL = (PTRW + 1)'(FQ_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // free to issue a request
    S_WAIT = 2'd1,  // request outstanding, response will be enqueued
    S_DROP = 2'd2   // request outstanding but squashed by a redirect
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     req_pc;
  logic            req_taken;
  logic [31:0]     req_target;

  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]     btb_target [BTB_ENTRIES];
  logic [1:0]      btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic            lk_taken;
  logic [31:0]     lk_next;

  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;
  logic            upd_we;
  logic [1:0]      upd_ctr_new;
  logic [31:0]     upd_tgt_new;
  logic            unused_upd_lsbs;

  logic [31:0]     fq_inst   [FQ_DEPTH];
  logic [31:0]     fq_pc     [FQ_DEPTH];
  logic            fq_taken  [FQ_DEPTH];
  logic [31:0]     fq_target [FQ_DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW:0]   count;
  logic            push;
  logic            pop;

  // --------------------------------------------------------------------------
  // BTB lookup for the current fetch PC. Reads the array contents as they
  // stand this cycle, so a same-cycle update is only seen on the next lookup.
  // --------------------------------------------------------------------------
  assign lk_idx   = pc[IDX+1:2];
  assign lk_tag   = pc[31:IDX+2];
  assign lk_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && btb_ctr[lk_idx][1];
  assign lk_next  = lk_taken ? btb_target[lk_idx] : pc + 32'd4;

  // --------------------------------------------------------------------------
  // BTB update. A taken miss allocates (overwriting whatever lived there) in
  // the weakly-taken state; a not-taken miss leaves the entry alone.
  // --------------------------------------------------------------------------
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[31:IDX+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  // Instruction-aligned PCs: the byte offset never takes part in the lookup.
  assign unused_upd_lsbs = ^upd_pc[1:0];

  always_comb begin
    upd_we      = 1'b0;
    upd_ctr_new = btb_ctr[upd_idx];
    upd_tgt_new = btb_target[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (upd_taken) begin
          upd_ctr_new = (btb_ctr[upd_idx] == 2'b11) ? 2'b11 : btb_ctr[upd_idx] + 2'b01;
          upd_tgt_new = upd_target;
        end else begin
          upd_ctr_new = (btb_ctr[upd_idx] == 2'b00) ? 2'b00 : btb_ctr[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        upd_we      = 1'b1;
        upd_ctr_new = 2'b10;
        upd_tgt_new = upd_target;
      end
    end
  end

  // One register set per entry; each is written only when the update
  // addresses it.
  for (genvar e = 0; e < BTB_ENTRIES; e++) begin : g_btb_entry
    logic            valid_q;
    logic [TAGW-1:0] tag_q;
    logic [31:0]     target_q;
    logic [1:0]      ctr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
        ctr_q    <= 2'b01;
      end else if (upd_we && (upd_idx == IDX'(e))) begin
        valid_q  <= 1'b1;
        tag_q    <= upd_tag;
        target_q <= upd_tgt_new;
        ctr_q    <= upd_ctr_new;
      end
    end

    assign btb_valid[e]  = valid_q;
    assign btb_tag[e]    = tag_q;
    assign btb_target[e] = target_q;
    assign btb_ctr[e]    = ctr_q;
  end

  // --------------------------------------------------------------------------
  // Request issue. Only the completed-entry count gates issue: with a single
  // outstanding request the queue can never be overrun by its response.
  // --------------------------------------------------------------------------
  assign imem_req  = (state == S_REQ) && (count < FQ_FULL) && !redirect_valid && !rst;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= TEXT_BASE;
      req_pc     <= '0;
      req_taken  <= 1'b0;
      req_target <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      // A response landing in the redirect cycle retires the outstanding
      // request (and is discarded), so there is nothing left to drop.
      if ((state != S_REQ) && !imem_rvalid) begin
        state <= S_DROP;
      end else begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req) begin
            req_pc     <= pc;
            req_taken  <= lk_taken;
            req_target <= lk_next;
            pc         <= lk_next;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fetch queue. Redirect flushes and overrides any push/pop in that cycle.
  // --------------------------------------------------------------------------
  assign push = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign pop  = inst_valid && deq_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; the head outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_inst[wr_ptr]   <= imem_rdata;
      fq_pc[wr_ptr]     <= req_pc;
      fq_taken[wr_ptr]  <= req_taken;
      fq_target[wr_ptr] <= req_target;
    end
  end

  assign inst_valid  = (count != '0);
  assign inst        = inst_valid ? fq_inst[rd_ptr]   : '0;
  assign inst_pc     = inst_valid ? fq_pc[rd_ptr]     : '0;
  assign pred_taken  = inst_valid ? fq_taken[rd_ptr]  : 1'b0;
  assign pred_target = inst_valid ? fq_target[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A transaction-level model
//            (queue of fetched entries, BTB table, expected fetch PC) tracks
//            what the front end should present each cycle; a simple memory
//            answers each request after a fixed or random latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] TEXT_BASE   = 32'h0040_0000;
  localparam int          BTB_ENTRIES = 16;
  localparam int          FQ_DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        deq_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  fetch_unit #(
    .TEXT_BASE  (TEXT_BASE),
    .BTB_ENTRIES(BTB_ENTRIES),
    .FQ_DEPTH   (FQ_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .deq_ready     (deq_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t      m_q[$];
  entry_t      m_out;
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_squash;
  bit          mb_valid  [BTB_ENTRIES];
  logic [31:0] mb_tag    [BTB_ENTRIES];
  logic [31:0] mb_target [BTB_ENTRIES];
  int          mb_ctr    [BTB_ENTRIES];

  // memory responder state
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat;
  bit          lat_rand;
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  function automatic int bidx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(BTB_ENTRIES));
  endfunction

  function automatic logic [31:0] btag(input logic [31:0] a);
    return a / 32'(4 * BTB_ENTRIES);
  endfunction

  function automatic logic [31:0] log_at(input int k);
    if (k < req_log.size()) return req_log[k];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pc     = TEXT_BASE;
    m_busy   = 1'b0;
    m_squash = 1'b0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      mb_valid[i]  = 1'b0;
      mb_tag[i]    = '0;
      mb_target[i] = '0;
      mb_ctr[i]    = 1;
    end
  endfunction

  function automatic void model_update(input logic [31:0] upc, input bit utk, input logic [31:0] utgt);
    int  i;
    bit  hit;
    i   = bidx(upc);
    hit = mb_valid[i] && (mb_tag[i] == btag(upc));
    if (hit) begin
      if (utk) begin
        if (mb_ctr[i] < 3) mb_ctr[i]++;
        mb_target[i] = utgt;
      end else if (mb_ctr[i] > 0) begin
        mb_ctr[i]--;
      end
    end else if (utk) begin
      mb_valid[i]  = 1'b1;
      mb_tag[i]    = btag(upc);
      mb_target[i] = utgt;
      mb_ctr[i]    = 2;
    end
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic do_reset();
    rst            = 1'b1;
    deq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    mem_pend       = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle with the given Decode/Execute inputs.
  task automatic cycle(input bit deq, input bit redir, input logic [31:0] rpc,
                       input bit upd, input logic [31:0] upc, input bit utk,
                       input logic [31:0] utgt);
    bit          exp_req;
    bit          exp_valid;
    bit          hit;
    bit          tk;
    int          i;
    logic [31:0] nxt;

    deq_ready      = deq;
    redirect_valid = redir;
    redirect_pc    = rpc;
    upd_valid      = upd;
    upd_pc         = upc;
    upd_taken      = utk;
    upd_target     = utgt;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 1'b0;
      end
    end

    @(negedge clk);
    exp_valid = (m_q.size() != 0);
    check("inst_valid", 32'(inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("inst", inst, m_q[0].inst);
      check("inst_pc", inst_pc, m_q[0].pc);
      check("pred_taken", 32'(pred_taken), 32'(m_q[0].taken));
      check("pred_target", pred_target, m_q[0].target);
    end else begin
      check("empty_inst", inst, 32'd0);
      check("empty_inst_pc", inst_pc, 32'd0);
      check("empty_pred_taken", 32'(pred_taken), 32'd0);
      check("empty_pred_target", pred_target, 32'd0);
    end
    exp_req = !m_busy && (m_q.size() < FQ_DEPTH) && !redir;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_pc);

    if (imem_req) begin
      req_log.push_back(imem_addr);
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = lat_rand ? int'($urandom_range(4, 1)) : lat;
    end

    if (redir) begin
      m_q.delete();
      m_pc = rpc;
      if (m_busy) begin
        if (imem_rvalid) begin
          m_busy   = 1'b0;
          m_squash = 1'b0;
        end else begin
          m_squash = 1'b1;
        end
      end
    end else begin
      if (deq && (m_q.size() != 0)) void'(m_q.pop_front());
      if (imem_rvalid && m_busy) begin
        if (!m_squash) m_q.push_back(m_out);
        m_busy   = 1'b0;
        m_squash = 1'b0;
      end
      if (exp_req) begin
        i   = bidx(m_pc);
        hit = mb_valid[i] && (mb_tag[i] == btag(m_pc));
        tk  = hit && (mb_ctr[i] >= 2);
        nxt = tk ? mb_target[i] : m_pc + 32'd4;
        m_out.inst   = mem_word(m_pc);
        m_out.pc     = m_pc;
        m_out.taken  = tk;
        m_out.target = nxt;
        m_busy   = 1'b1;
        m_squash = 1'b0;
        m_pc     = nxt;
      end
    end
    // Update lands after the lookup: same-cycle lookups see the old entry.
    if (upd) model_update(upc, utk, utgt);

    @(posedge clk); #1;
  endtask

  task automatic idle(input bit deq, input int n);
    for (int k = 0; k < n; k++) cycle(deq, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic redirect_to(input bit deq, input logic [31:0] a);
    cycle(deq, 1'b1, a, 1'b0, '0, 1'b0, '0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    lat      = 1;
    lat_rand = 1'b0;

    // Sequential fetch with a 1-cycle memory.
    do_reset();
    req_log.delete();
    idle(1'b1, 6);
    check("seq_nreq", 32'(req_log.size()), 32'd3);
    check("seq_addr0", log_at(0), 32'h0040_0000);
    check("seq_addr1", log_at(1), 32'h0040_0004);
    check("seq_addr2", log_at(2), 32'h0040_0008);

    // Back-pressure: queue fills, then one dequeue frees one request slot.
    do_reset();
    req_log.delete();
    idle(1'b0, 20);
    check("full_nreq", 32'(req_log.size()), 32'd4);
    check("full_req_low", 32'(imem_req), 32'd0);
    idle(1'b1, 1);
    idle(1'b0, 10);
    check("deq_nreq", 32'(req_log.size()), 32'd5);
    check("deq_addr", log_at(4), 32'h0040_0010);

    // Redirect while a 3-cycle request is outstanding with entries queued.
    lat = 3;
    do_reset();
    idle(1'b0, 10);
    req_log.delete();
    redirect_to(1'b0, 32'h0040_0100);
    check("redir_flush", 32'(inst_valid), 32'd0);
    idle(1'b0, 8);
    check("redir_addr", log_at(0), 32'h0040_0100);

    // Taken update, then a fetch through the predicted branch.
    lat = 1;
    do_reset();
    req_log.delete();
    cycle(1'b1, 1'b0, '0, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0040);
    idle(1'b1, 8);
    check("btb_taken", log_at(3), 32'h0040_0040);

    // Weakening: one not-taken update drops below the taken threshold.
    cycle(1'b1, 1'b0, '0, 1'b1, 32'h0040_0008, 1'b0, '0);
    req_log.delete();
    redirect_to(1'b1, 32'h0040_0000);
    idle(1'b1, 10);
    check("btb_weak_nt", log_at(3), 32'h0040_000C);
    cycle(1'b1, 1'b0, '0, 1'b1, 32'h0040_0008, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0040);
    req_log.delete();
    redirect_to(1'b1, 32'h0040_0000);
    idle(1'b1, 10);
    check("btb_ctr1_nt", log_at(3), 32'h0040_000C);

    // Update and lookup of the same index in the same cycle.
    do_reset();
    req_log.delete();
    cycle(1'b1, 1'b0, '0, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0080);
    idle(1'b1, 6);
    check("same_cyc_old", log_at(1), 32'h0040_0004);
    req_log.delete();
    redirect_to(1'b1, 32'h0040_0000);
    idle(1'b1, 10);
    check("same_cyc_new", log_at(1), 32'h0040_0080);

    // Randomised traffic with occasional mid-flight resets.
    lat_rand = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299, 0) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(3, 0) != 0,
              $urandom_range(19, 0) == 0,
              TEXT_BASE + 32'(4 * $urandom_range(63, 0)),
              $urandom_range(4, 0) == 0,
              TEXT_BASE + 32'(4 * $urandom_range(63, 0)),
              $urandom_range(1, 0) == 1,
              TEXT_BASE + 32'(4 * $urandom_range(63, 0)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end with a direct-mapped branch target buffer (BTB), 2-bit saturating direction counters and a decoupling fetch queue. It sits between the L1 instruction cache and Decode. It replaces stall-on-branch fetch with predicted next-PC generation and execute-stage redirect.

## Interface
- TEXT_BASE, 32'h0040_0000, reset PC
- BTB_ENTRIES, 16, BTB entries; power of two, ≥2
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  cache request valid for the current cycle
- imem_addr  out  32  request address (fetch PC)
- imem_rvalid  in  1  response valid; single-cycle pulse, any latency ≥1
- imem_rdata  in  32  response instruction
- inst_valid  out  1  queue head valid
- inst  out  32  head instruction
- inst_pc  out  32  head PC
- pred_taken  out  1  head predicted taken
- pred_target  out  32  head predicted next PC
- deq_ready  in  1  Decode consumes head when inst_valid=1
- redirect_valid  in  1  mispredict or jump from execute
- redirect_pc  in  32  corrected PC
- upd_valid  in  1  resolved branch update
- upd_pc  in  32  branch PC
- upd_taken  in  1  resolved direction
- upd_target  in  32  resolved target

## Operation
- IDX = log2(BTB_ENTRIES). Index = pc[IDX+1:2]. Tag = pc[31:IDX+2]. Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Prediction is made at request issue. Hit = valid && tag match. Taken = hit && ctr[1]. next_pc = taken ? target : pc+4, with 32-bit wrap.
- FSM REQ / WAIT / DROP:
  - REQ: imem_req = (count + 0) < FQ_DEPTH. On request, latch {pc, pred_taken, next_pc}, set pc ← next_pc, go to WAIT. No request while the queue is full.
  - WAIT: imem_req=0. On imem_rvalid, push {rdata, latched pc, pred} and go to REQ.
  - DROP: awaits the response of a squashed request. On imem_rvalid, discard it and go to REQ.
- Only one request is outstanding at a time.
- Redirect, in any state: pc ← redirect_pc, queue flushed (count=0). WAIT → DROP; REQ stays REQ with no request that cycle; DROP stays DROP. A response arriving in the same cycle as the redirect is discarded.
- Queue: circular FIFO, pointers wrap modulo FQ_DEPTH. Push and pop may occur in the same cycle; count is unchanged. A push when the queue is full cannot happen because of the issue rule. Redirect overrides both push and pop.
- BTB update on upd_valid:
  - Hit, taken: ctr saturating increment (max 3), target ← upd_target.
  - Hit, not taken: ctr saturating decrement (min 0).
  - Miss, taken: allocate valid=1, tag, target, ctr=2'b10. Any victim is overwritten.
  - Miss, not taken: no change.
- Update and lookup in the same cycle at the same index: the lookup sees the pre-update contents. The write is visible the next cycle.

## Timing
- Reset values: pc=TEXT_BASE, state=REQ, count=0, inst_valid=0, all BTB valid=0, ctr=2'b01. Outputs inst, inst_pc, pred_taken and pred_target are 0 while empty.
- First imem_req=1 occurs in the cycle after rst deasserts, with imem_addr=TEXT_BASE.
- A response in cycle t sets inst_valid=1 at t+1.
- Throughput is 1 instruction per (latency+1) cycles.
- rst mid-transaction returns the FSM to REQ. A stale imem_rvalid seen in REQ is ignored.
- After redirect in cycle t: inst_valid=0 at t+1. imem_addr=redirect_pc at t+1 if the prior state was REQ; otherwise at the cycle after the squashed response.

## Test plan
- Reset, 1-cycle memory, deq_ready=1: addresses 0x00400000, 0x00400004, 0x00400008 on every other cycle. inst_pc matches each address; pred_taken=0.
- deq_ready=0: exactly FQ_DEPTH (4) requests, then imem_req held 0. One dequeue → one new request.
- Redirect to 0x00400100 while WAIT with 3-cycle latency: squashed response not enqueued, next imem_addr=0x00400100, inst_valid=0 at t+1.
- upd taken pc=0x00400008 → target 0x00400040: subsequent fetch of 0x00400008 gives pred_taken=1, next imem_addr=0x00400040.
- Two not-taken updates on that entry (ctr 2→1→0): pred_taken=0 after the first update. One taken update afterwards → ctr=1, still not taken.
- Update and lookup of the same index in the same cycle: the lookup uses the old entry (miss, pc+4); the following fetch of that index hits.
